muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative integer multiply/divide unit, one result bit per clock.
//   Multiply uses a radix-2 shift-add loop; divide uses a restoring
//   shift-subtract loop. Both loops work on operand magnitudes. A final
//   fix-up cycle applies the two's-complement sign correction.
//
// Ports
//   clk    : single clock, all state changes on the rising edge
//   reset  : synchronous, active-high; forces IDLE and clears every output
//   start  : request a new operation (honoured only when not busy)
//   mode   : 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
//   a, b   : multiplicand/multiplier or dividend/divisor
//   hi, lo : result; {hi,lo} = product, or hi = remainder / lo = quotient
//   busy   : operation in progress (RUN and FIX states)
//   done   : one-cycle pulse, result or dzero valid
//   dzero  : divide-by-zero flag for the last operation
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             dzero
);

    // Counter spans 0..WIDTH: slot 0 conditions the operands, slots 1..WIDTH
    // each perform one iteration step.
    localparam int              CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Magnitude of an operand; unsigned operations pass it through untouched.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                                 input logic            is_signed);
        logic [WIDTH-1:0] r;
        if (is_signed && v[WIDTH-1]) begin
            r = {WIDTH{1'b0}} - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Conditional two's-complement negation of a WIDTH-bit value.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic            neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = {WIDTH{1'b0}} - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [1:0]         state_r;
    logic [CW-1:0]      cnt_r;
    logic [1:0]         mode_r;
    logic [WIDTH-1:0]   rem_r;      // upper half: partial product or remainder
    logic [WIDTH-1:0]   quo_r;      // lower half: multiplier/product or quotient
    logic [WIDTH-1:0]   dvs_r;      // multiplicand or divisor magnitude
    logic               neg_q_r;    // product / quotient sign
    logic               neg_r_r;    // remainder sign
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;
    logic               dzero_r;

    logic               is_div_s;
    logic               is_signed_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_sh_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   step_rem_s;
    logic [WIDTH-1:0]   step_quo_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    // One iteration step of either the shift-add multiply or restoring divide.
    always_comb begin
        is_div_s    = mode_r[1];
        is_signed_s = ~mode_r[0];
        mul_sum_s   = {1'b0, rem_r} + (quo_r[0] ? {1'b0, dvs_r} : {(WIDTH+1){1'b0}});
        div_sh_s    = {rem_r, quo_r[WIDTH-1]};
        div_ge_s    = (div_sh_s >= {1'b0, dvs_r});
        step_rem_s  = rem_r;
        step_quo_s  = quo_r;
        if (is_div_s) begin
            // When the trial subtract succeeds the true difference is below
            // the divisor, so modular WIDTH-bit subtraction is exact.
            if (div_ge_s) begin
                step_rem_s = div_sh_s[WIDTH-1:0] - dvs_r;
            end else begin
                step_rem_s = div_sh_s[WIDTH-1:0];
            end
            step_quo_s = {quo_r[WIDTH-2:0], div_ge_s};
        end else begin
            step_rem_s = mul_sum_s[WIDTH:1];
            step_quo_s = {mul_sum_s[0], quo_r[WIDTH-1:1]};
        end
    end

    // Sign correction applied in the FIX cycle.
    always_comb begin
        prod_s     = {rem_r, quo_r};
        prod_fix_s = neg_q_r ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;
        if (is_div_s) begin
            fix_lo_s = cond_neg(quo_r, neg_q_r);
            fix_hi_s = cond_neg(rem_r, neg_r_r);
        end else begin
            fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            mode_r  <= 2'b00;
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
            dvs_r   <= {WIDTH{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dzero_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        // Raw operands are latched; magnitudes are taken in
                        // the first RUN slot to keep the accept path short.
                        mode_r  <= mode;
                        quo_r   <= a;
                        dvs_r   <= b;
                        rem_r   <= {WIDTH{1'b0}};
                        cnt_r   <= CNT_ZERO;
                        dzero_r <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (cnt_r == CNT_ZERO) begin
                        if (is_div_s && (dvs_r == {WIDTH{1'b0}})) begin
                            // Divide by zero: report at once, results untouched.
                            dzero_r <= 1'b1;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_DONE;
                        end else begin
                            quo_r   <= abs_val(quo_r, is_signed_s);
                            dvs_r   <= abs_val(dvs_r, is_signed_s);
                            neg_q_r <= is_signed_s & (quo_r[WIDTH-1] ^ dvs_r[WIDTH-1]);
                            neg_r_r <= is_signed_s & quo_r[WIDTH-1];
                            cnt_r   <= CNT_ONE;
                        end
                    end else begin
                        rem_r <= step_rem_s;
                        quo_r <= step_quo_s;
                        cnt_r <= cnt_r + CNT_ONE;
                        if (cnt_r == CNT_LAST) begin
                            state_r <= ST_FIX;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_FIX: begin
                    hi_r    <= fix_hi_s;
                    lo_r    <= fix_lo_s;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_DONE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign hi    = hi_r;
    assign lo    = lo_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign dzero = dzero_r;

endmodule
